// File: rtl/filter_peak_detector_pkg.sv
// Shared settings and types for the filter peak detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package filter_peak_detector_pkg;

    // Filter front-end settings
    localparam int SIZE_FILTER_DATA  = 16;
    localparam int SIZE_TEST_COUNTER = 16;
    localparam int SIZE_DELAY        = 7;
    localparam int DELAY_DATA        = 14;

    // One detected pulse: peak amplitude, timestamp of first peak sample, width
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA-1:0]  amp;
        logic        [SIZE_TEST_COUNTER-1:0] tstamp;
        logic        [SIZE_DELAY-1:0]        width;
    } peak_event_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ABOVE = 2'd1,
        HOLD  = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/filter_peak_detector_fifo.sv
// Show-ahead FIFO of peak events with full/empty flags.
// Latency: a push is visible at head_o the cycle after the write edge.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module peak_event_fifo
    import filter_peak_detector_pkg::*;
#(
    parameter type T  = peak_event_t,
    parameter int  AW = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push_i,
    input  T     push_dat_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int DEPTH = 1 << AW;

    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    // Occupancy reaches DEPTH exactly when the extra count bit is set
    assign empty_o = (cnt_q == '0);
    assign full_o  = cnt_q[AW];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_q];

    // Storage, pointers and occupancy; storage is cleared so outputs read zero after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= push_dat_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/filter_peak_detector.sv
// Threshold pulse detector: measures peak amplitude, peak timestamp and width per pulse.
// Latency: event enters the FIFO one edge after the falling sample; out_valid the edge after.
// Backpressure: 4-deep result FIFO; events arriving while it is full are dropped and flagged.
module filter_peak_detector
    import filter_peak_detector_pkg::*;
#(
    parameter int DATA_W  = SIZE_FILTER_DATA,
    parameter int TS_W    = SIZE_TEST_COUNTER,
    parameter int WIDTH_W = SIZE_DELAY,
    parameter int HOLDOFF = DELAY_DATA,
    parameter int FIFO_AW = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic signed [DATA_W-1:0]  threshold,
    input  logic                      filt_valid,
    input  logic signed [DATA_W-1:0]  filt_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATA_W-1:0]  out_amp,
    output logic        [TS_W-1:0]    out_time,
    output logic        [WIDTH_W-1:0] out_width,
    output logic                      overflow,
    output logic                      busy
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    typedef struct packed {
        logic signed [DATA_W-1:0]  amp;
        logic        [TS_W-1:0]    tstamp;
        logic        [WIDTH_W-1:0] width;
    } event_t;

    fsm_state_t               state_q;
    logic        [TS_W-1:0]   ts_q;
    logic signed [DATA_W-1:0] amp_q;
    logic        [TS_W-1:0]   time_q;
    logic        [WIDTH_W-1:0] width_q;
    logic        [HW-1:0]     hold_q;
    logic                     push_q;
    logic                     busy_q;
    logic                     overflow_q;

    logic   above;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    event_t push_dat;
    event_t head;

    assign above     = filt_data > threshold;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push_dat  = '{amp: amp_q, tstamp: time_q, width: width_q};

    // Sample timestamp advances on every valid sample regardless of enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts_q <= '0;
        else if (filt_valid) ts_q <= ts_q + 1'b1;
    end

    // Pulse tracker; the captured event stays in amp_q/time_q/width_q through the write edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            amp_q   <= '0;
            time_q  <= '0;
            width_q <= '0;
            hold_q  <= '0;
            push_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (!enable) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (filt_valid && above) begin
                            amp_q   <= filt_data;
                            time_q  <= ts_q;
                            width_q <= WIDTH_W'(1);
                            state_q <= ABOVE;
                            busy_q  <= 1'b1;
                        end
                    end
                    ABOVE: begin
                        if (filt_valid) begin
                            if (above) begin
                                if (width_q != WIDTH_MAX) width_q <= width_q + 1'b1;
                                // Strict compare: an equal later peak keeps the earlier timestamp
                                if (filt_data > amp_q) begin
                                    amp_q  <= filt_data;
                                    time_q <= ts_q;
                                end
                            end else begin
                                push_q  <= 1'b1;
                                hold_q  <= HW'(HOLDOFF);
                                state_q <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        // Counter reaching zero on this edge releases the detector
                        if (hold_q <= HW'(1)) begin
                            hold_q  <= '0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky drop flag: a push into a full FIFO with no simultaneous pop is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) overflow_q <= 1'b0;
        else if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
    end

    peak_event_fifo #(
        .T  (event_t),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (push_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_amp   = head.amp;
    assign out_time  = head.tstamp;
    assign out_width = head.width;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_filter_peak_detector.sv
// Scoreboard bench for filter_peak_detector.
// Latency: expected events queued at stimulus time, compared at each accepted output.
// Backpressure: exercises stalled readout, FIFO overflow and drain.
module tb_filter_peak_detector;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               enable;
    logic signed [15:0] threshold;
    logic               filt_valid;
    logic signed [15:0] filt_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_amp;
    logic        [15:0] out_time;
    logic        [6:0]  out_width;
    logic               overflow;
    logic               busy;

    typedef struct {
        logic [15:0] amp;
        logic [15:0] t;
        logic [6:0]  w;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ts_m  = 0;

    filter_peak_detector dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .threshold  (threshold),
        .filt_valid (filt_valid),
        .filt_data  (filt_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_amp    (out_amp),
        .out_time   (out_time),
        .out_width  (out_width),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] amp, input int t, input logic [6:0] w);
        exp_t e;
        e.amp = amp;
        e.t   = 16'(t);
        e.w   = w;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic signed [15:0] d);
        @(posedge clk);
        #1;
        filt_valid = 1'b1;
        filt_data  = d;
        ts_m++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            filt_valid = 1'b0;
        end
    endtask

    // Compare every accepted event against the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_event", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("evt_amp",   32'($unsigned(out_amp)), 32'(e.amp));
                check_eq("evt_time",  32'(out_time),  32'(e.t));
                check_eq("evt_width", 32'(out_width), 32'(e.w));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n    = 1'b0;
        enable     = 1'b0;
        threshold  = 16'sd100;
        filt_valid = 1'b0;
        filt_data  = '0;
        out_ready  = 1'b1;
        #23;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_amp",   32'($unsigned(out_amp)), 32'd0);
        check_eq("rst_out_time",  32'(out_time), 32'd0);
        check_eq("rst_out_width", 32'(out_width), 32'd0);
        check_eq("rst_overflow",  32'(overflow), 32'd0);
        check_eq("rst_busy",      32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;

        // Basic pulse, latency and holdoff boundary
        push_exp(16'd300, 3, 7'd4);
        send(0); send(50); send(150); send(300); send(300); send(200);
        send(90);
        send(0);
        check_eq("lat_valid_early", 32'(out_valid), 32'd0);
        check_eq("lat_busy_hold",   32'(busy), 32'd1);
        idle(1);
        check_eq("lat_valid_on", 32'(out_valid), 32'd1);
        idle(12);
        check_eq("hold_busy_last", 32'(busy), 32'd1);
        idle(1);
        check_eq("hold_busy_done", 32'(busy), 32'd0);
        idle(5);

        // Long pulse saturates the width
        push_exp(16'd500, ts_m, 7'd127);
        repeat (200) send(500);
        send(0);
        idle(20);

        // Second pulse inside holdoff is ignored
        push_exp(16'd300, ts_m, 7'd3);
        repeat (3) send(300);
        repeat (5) send(0);
        repeat (3) send(400);
        send(0);
        idle(20);

        // Second pulse after the holdoff is reported
        push_exp(16'd300, ts_m, 7'd3);
        repeat (3) send(300);
        repeat (20) send(0);
        push_exp(16'd400, ts_m, 7'd2);
        repeat (2) send(400);
        send(0);
        idle(20);

        // Stalled readout: four queued, rest dropped
        out_ready = 1'b0;
        t = ts_m;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) push_exp(16'(200 + 10 * k), ts_m, 7'd2);
            repeat (2) send(16'(200 + 10 * k));
            send(0);
            idle(16);
        end
        check_eq("ovf_set",       32'(overflow), 32'd1);
        check_eq("ovf_out_valid", 32'(out_valid), 32'd1);
        repeat (3) begin
            idle(1);
            check_eq("stall_amp",  32'($unsigned(out_amp)), 32'd200);
            check_eq("stall_time", 32'(out_time), 32'(t));
        end
        out_ready = 1'b1;
        idle(8);
        check_eq("drain_empty", 32'(out_valid), 32'd0);
        check_eq("drain_sb",    32'(exp_q.size()), 32'd0);

        // Enable dropped mid-pulse discards the pulse
        repeat (3) send(300);
        enable = 1'b0;
        send(300);
        check_eq("en_busy", 32'(busy), 32'd0);
        send(0);
        idle(3);
        enable = 1'b1;
        idle(3);
        check_eq("en_no_event", 32'(out_valid), 32'd0);

        // Reset while an event is waiting
        out_ready = 1'b0;
        repeat (2) send(300);
        send(0);
        idle(3);
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_amp",   32'($unsigned(out_amp)), 32'd0);
        check_eq("mid_rst_time",  32'(out_time), 32'd0);
        check_eq("mid_rst_width", 32'(out_width), 32'd0);
        check_eq("mid_rst_ovf",   32'(overflow), 32'd0);
        check_eq("mid_rst_busy",  32'(busy), 32'd0);
        ts_m = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Negative threshold
        out_ready = 1'b1;
        threshold = -16'sd200;
        push_exp(16'hFF9C, 1, 7'd1);
        send(-300);
        send(-100);
        send(-250);
        idle(20);

        idle(5);
        check_eq("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filter_peak_detector.md
# filter_peak_detector

Downstream stage of the shaping filter: consumes the signed 16-bit filter output stream, detects pulses crossing a programmable threshold and measures each one's peak amplitude, peak timestamp and width. Results are queued in a small FIFO and read out over a valid/ready interface by the readout/test-RAM logic. Sits between the filter and the event readout.

## Interface
- DATA_W, default SIZE_FILTER_DATA (16): filter sample width, signed two's complement
- TS_W, default SIZE_TEST_COUNTER (16): timestamp width
- WIDTH_W, default SIZE_DELAY (7): pulse-width field; saturates at 2^WIDTH_W-1
- HOLDOFF, default DELAY_DATA (14): dead time in clk cycles after each pulse
- FIFO_AW, default 2: FIFO address width (depth 4)
- clk  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  detector run enable
- threshold  in  DATA_W  signed threshold; quasi-static, sampled every cycle
- filt_valid  in  1  filt_data qualifier
- filt_data  in  DATA_W  signed filter output
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts event
- out_amp  out  DATA_W  peak amplitude (signed)
- out_time  out  TS_W  timestamp of first peak sample
- out_width  out  WIDTH_W  above-threshold sample count, saturated
- overflow  out  1  sticky: event dropped because FIFO full
- busy  out  1  FSM not in IDLE

## Operation
- Timestamp counter ts: TS_W bits, +1 on every filt_valid sample (whether or not enable is high), wraps 0xFFFF->0.
- FSM states IDLE, ABOVE, HOLD.
- IDLE: on valid sample with enable=1 and filt_data > threshold (signed, strict): amp<=data, time<=ts, width<=1, go ABOVE.
- ABOVE, valid sample:
  - data > threshold: width+=1 saturating at 127; if data > amp (strict), amp<=data, time<=ts. Equal peaks keep the earlier time.
  - data <= threshold: push {amp,time,width} to FIFO, load hold counter with HOLDOFF, go HOLD.
- HOLD: counter decrements every clk; all samples ignored; at 0 go IDLE.
- No valid sample: FSM holds state (except HOLD counting).
- enable=0: FSM goes IDLE at next edge, in-progress pulse discarded, no push. FIFO contents and overflow retained.
- FIFO full at push: event dropped, overflow<=1. A push coinciding with a pop while full is accepted. overflow clears only on reset.
- Output: out_* reflect FIFO head; pop when out_valid && out_ready. out_* hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_amp=0, out_time=0, out_width=0, overflow=0, busy=0; ts=0; FSM IDLE; FIFO empty.
- Latency: the falling sample is captured at edge N; FIFO write at edge N+1; out_valid=1 after edge N+1 when the FIFO was empty.
- busy=1 from the edge after the rising sample until the edge where HOLD reaches 0.
- Pulse to pulse: next rising sample accepted no earlier than HOLDOFF+1 clk after the falling edge.
- Reset asserted mid-pulse or mid-readout: all state cleared immediately; no partial event.
- Throughput: one pop per clk.

## Structure
- Parameters come from package_settings (SIZE_FILTER_DATA, SIZE_TEST_COUNTER, SIZE_DELAY, DELAY_DATA).
- Add to the package: typedef struct packed peak_event_t {amp, time, width}; enum fsm_state_t {IDLE, ABOVE, HOLD}.
- Sub-module peak_event_fifo: synchronous show-ahead FIFO of peak_event_t, depth 2^FIFO_AW, with full/empty flags and simultaneous push/pop support.

## Test plan
- threshold=100; ts starts at 0; continuous samples 0,50,150,300,300,200,90,0; out_ready=1 -> one event: amp=300, time=3, width=4; out_valid is high 1 clk after sample 90 is captured.
- Pulse of 200 samples at 500 -> width=127, amp=500, time equals the first sample's ts.
- Two pulses separated by 5 clk below threshold (HOLDOFF=14) -> only the first is reported; with a 20 clk gap, both are reported.
- out_ready=0, 6 pulses -> 4 events queued, overflow=1; drain -> the first four are read in order, out_* stable while stalled.
- enable dropped mid-pulse -> no event, busy=0 next clk; reset_n pulsed low while out_valid=1 -> all outputs 0 immediately.
- Negative threshold -200 with samples -300,-100,-250 -> event amp=-100, width=1.
